// File: rtl/fetch_read_responder_pkg.sv
// Shared types for the fetch read protocol: addresses, bus IDs, packet types, request/response records.
// No logic here; latency and backpressure are properties of the modules that use these types.
// Packet type encodings are shared with requesters and must not be renumbered.
package fetch_read_responder_pkg;

    typedef logic [63:0] memory_address_t;
    typedef logic [15:0] bus_id_t;
    typedef logic [31:0] instruction_t;

    typedef enum logic [7:0] {
        bus_read_request   = 8'h01,
        bus_read_response  = 8'h02,
        bus_error_response = 8'h03
    } bus_packet_type_t;

    typedef struct packed {
        memory_address_t address;
        bus_id_t         bus_id;
    } bus_request_t;

    typedef struct packed {
        bus_packet_type_t packet_type;
        logic [63:0]      payload;
        bus_id_t          bus_id;
    } bus_response_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESPOND
    } fsm_state_t;

endpackage

// File: rtl/fetch_read_responder_fifo.sv
// bus_request_fifo: pending read request queue, power-of-2 depth, head visible combinationally.
// Latency: pushed entry visible at the head the cycle after the push edge.
// Backpressure: push refused while full; full comes from registered occupancy, so a same-cycle pop does not free a slot.
module bus_request_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 80
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign head_dat = store[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) store[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/fetch_read_responder.sv
// Memory-side fetch read responder: queued in-order reads of 64-bit instruction words, error for out-of-range addresses.
// Latency: response valid 1+READ_LATENCY edges after the accepting edge when idle; one response per READ_LATENCY+1 cycles.
// Backpressure: req_ready drops when the request queue is full; an unaccepted response is held stable.
module fetch_read_responder
    import fetch_read_responder_pkg::*;
#(
    parameter int MEM_WORDS      = 1024,
    parameter int READ_LATENCY   = 3,
    parameter int REQ_FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [63:0]                  req_address,
    input  logic [15:0]                  req_bus_id,
    output logic                         resp_valid,
    input  logic                         resp_accept,
    output logic [7:0]                   resp_type,
    output logic [63:0]                  resp_payload,
    output logic [15:0]                  resp_bus_id,
    input  logic                         load_en,
    input  logic [$clog2(MEM_WORDS)-1:0] load_index,
    input  logic [63:0]                  load_data,
    output logic                         stat_stall
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int RW = $bits(bus_request_t);

    logic [63:0]   mem [MEM_WORDS];

    fsm_state_t    state;
    fsm_state_t    state_nxt;
    logic [CW-1:0] cnt;
    bus_request_t  cur_req;
    bus_response_t resp_q;

    bus_request_t  push_req;
    bus_request_t  head_req;
    logic [RW-1:0] head_bits;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic          resp_latch;

    logic [AW-1:0] rd_idx;
    logic [63:0]   rd_word;
    logic          in_range;
    logic          unused_addr_low;

    assign push_req  = '{address: req_address, bus_id: req_bus_id};
    assign head_req  = head_bits;
    assign req_ready = !fifo_full;

    bus_request_fifo #(
        .DEPTH (REQ_FIFO_DEPTH),
        .WIDTH (RW)
    ) u_req_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (req_valid),
        .push_dat (push_req),
        .pop      (fifo_pop),
        .head_dat (head_bits),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Requesters align addresses themselves; the byte offset carries no information.
    assign unused_addr_low = ^cur_req.address[2:0];
    assign rd_idx          = cur_req.address[3 +: AW];
    assign in_range        = (cur_req.address[63:3+AW] == '0);

    // Write-first: a load landing on the word being read this cycle is what gets returned.
    always_comb begin
        rd_word = mem[rd_idx];
        if (load_en && (load_index == rd_idx)) rd_word = load_data;
    end

    always_ff @(posedge clk) begin
        if (load_en) mem[load_index] <= load_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (!fifo_empty) state_nxt = ST_WAIT;
            ST_WAIT:    if (cnt == '0)   state_nxt = ST_RESPOND;
            ST_RESPOND: if (resp_accept) state_nxt = fifo_empty ? ST_IDLE : ST_WAIT;
            default:                     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_pop   = 1'b0;
        resp_latch = 1'b0;
        stat_stall = 1'b0;
        unique case (state)
            ST_IDLE:    fifo_pop   = !fifo_empty;
            ST_WAIT:    resp_latch = (cnt == '0);
            ST_RESPOND: begin
                fifo_pop   = resp_accept && !fifo_empty;
                stat_stall = !resp_accept;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            cur_req    <= '0;
            resp_valid <= 1'b0;
            resp_q     <= '{packet_type: bus_read_response, payload: 64'h0, bus_id: 16'h0};
        end else begin
            if (fifo_pop) begin
                cur_req <= head_req;
                cnt     <= CW'(READ_LATENCY - 1);
            end else if ((state == ST_WAIT) && (cnt != '0)) begin
                cnt <= cnt - CW'(1);
            end

            if (resp_latch) begin
                resp_valid         <= 1'b1;
                resp_q.bus_id      <= cur_req.bus_id;
                resp_q.packet_type <= in_range ? bus_read_response : bus_error_response;
                resp_q.payload     <= in_range ? rd_word : 64'h0;
            end else if ((state == ST_RESPOND) && resp_accept) begin
                resp_valid <= 1'b0;
            end
        end
    end

    assign resp_type    = resp_q.packet_type;
    assign resp_payload = resp_q.payload;
    assign resp_bus_id  = resp_q.bus_id;

endmodule

// File: tb/tb_fetch_read_responder.sv
// Scoreboard bench for fetch_read_responder: directed protocol cases then randomized traffic with random backpressure.
// Expected responses come from a shadow word array indexed by address/8 and are queued at request issue.
module tb_fetch_read_responder;
    import fetch_read_responder_pkg::*;

    localparam int MEM_WORDS = 1024;
    localparam int LAT       = 3;
    localparam int DEPTH     = 4;
    localparam int AW        = $clog2(MEM_WORDS);

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [63:0]   req_address;
    logic [15:0]   req_bus_id;
    logic          resp_valid;
    logic          resp_accept;
    logic [7:0]    resp_type;
    logic [63:0]   resp_payload;
    logic [15:0]   resp_bus_id;
    logic          load_en;
    logic [AW-1:0] load_index;
    logic [63:0]   load_data;
    logic          stat_stall;

    always #5 clk = ~clk;

    fetch_read_responder #(
        .MEM_WORDS      (MEM_WORDS),
        .READ_LATENCY   (LAT),
        .REQ_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_address  (req_address),
        .req_bus_id   (req_bus_id),
        .resp_valid   (resp_valid),
        .resp_accept  (resp_accept),
        .resp_type    (resp_type),
        .resp_payload (resp_payload),
        .resp_bus_id  (resp_bus_id),
        .load_en      (load_en),
        .load_index   (load_index),
        .load_data    (load_data),
        .stat_stall   (stat_stall)
    );

    typedef struct {
        logic [7:0]  t;
        logic [63:0] p;
        logic [15:0] id;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] model_mem [MEM_WORDS];
    int          n_cmp = 0;
    int          n_fail = 0;
    bit          rnd_mode = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic exp_t model(input logic [63:0] addr, input logic [15:0] id);
        exp_t e;
        e.id = id;
        if (addr >= 64'(MEM_WORDS) * 64'd8) begin
            e.t = bus_error_response;
            e.p = 64'h0;
        end else begin
            e.t = bus_read_response;
            e.p = model_mem[int'(addr / 64'd8)];
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_mode) resp_accept = ($urandom_range(0, 3) != 0);
    endtask

    task automatic raw_load(input int idx, input logic [63:0] data);
        load_en    = 1'b1;
        load_index = AW'(idx);
        load_data  = data;
        tick();
        load_en    = 1'b0;
    endtask

    task automatic do_load(input int idx, input logic [63:0] data);
        model_mem[idx] = data;
        raw_load(idx, data);
    endtask

    task automatic issue(input logic [63:0] a, input logic [15:0] id);
        int k;
        req_valid   = 1'b1;
        req_address = a;
        req_bus_id  = id;
        for (k = 0; k < 200; k++) begin
            if (req_ready) break;
            tick();
        end
        if (k == 200) begin
            timeout("req_ready_wait");
        end else begin
            exp_q.push_back(model(a, id));
            tick();
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int k;
        for (k = 0; k < 100; k++) begin
            if (resp_valid) break;
            tick();
        end
        if (k == 100) timeout("resp_valid_wait");
    endtask

    task automatic wait_idle();
        int k;
        rnd_mode    = 1'b0;
        resp_accept = 1'b1;
        for (k = 0; k < 500; k++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        if (k == 500) timeout("drain");
        tick();
    endtask

    // Scoreboard monitor: every completed handshake pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && resp_valid && resp_accept) begin
                check("stall_on_accept", 64'(stat_stall), 64'h0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got id %h payload %h, expected no response", resp_bus_id, resp_payload);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_type", 64'(resp_type), 64'(e.t));
                    check("resp_payload", resp_payload, e.p);
                    check("resp_bus_id", 64'(resp_bus_id), 64'(e.id));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        logic [63:0] a;
        logic [63:0] word_b;
        logic [63:0] word_c;

        reset       = 1'b1;
        req_valid   = 1'b0;
        req_address = '0;
        req_bus_id  = '0;
        resp_accept = 1'b0;
        load_en     = 1'b0;
        load_index  = '0;
        load_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_valid", 64'(resp_valid), 64'h0);
        check("rst_resp_type", 64'(resp_type), 64'(bus_read_response));
        check("rst_resp_payload", resp_payload, 64'h0);
        check("rst_resp_bus_id", 64'(resp_bus_id), 64'h0);
        check("rst_stat_stall", 64'(stat_stall), 64'h0);
        check("rst_req_ready", 64'(req_ready), 64'h1);
        reset = 1'b0;
        tick();

        for (int i = 0; i < MEM_WORDS; i++) do_load(i, {$urandom, $urandom});

        // Basic read and latency from the accepting edge.
        do_load(0, 64'h0000_0002_0000_0001);
        resp_accept = 1'b1;
        issue(64'h0, 16'h0101);
        check("valid_at_accept_edge", 64'(resp_valid), 64'h0);
        for (k = 1; k <= 20; k++) begin
            tick();
            if (resp_valid) break;
        end
        check("first_latency", 64'(k), 64'(1 + LAT));
        check("first_payload", resp_payload, 64'h0000_0002_0000_0001);
        wait_idle();

        // Unaligned and boundary addresses.
        issue(64'h0C, 16'h0202);
        issue(64'h0F, 16'h0203);
        issue(64'(MEM_WORDS * 8), 16'h0303);
        issue(64'(MEM_WORDS * 8 - 1), 16'h0304);
        issue(64'hFFFF_FFFF_FFFF_FFF8, 16'h0305);
        wait_idle();

        // Fill the queue behind a stalled response.
        resp_accept = 1'b0;
        for (int i = 0; i < 5; i++) issue(64'(i * 8), 16'h0400 + 16'(i));
        check("ready_low_when_full", 64'(req_ready), 64'h0);
        req_valid   = 1'b1;
        req_address = 64'h40;
        req_bus_id  = 16'hDEAD;
        repeat (3) tick();
        req_valid = 1'b0;
        check("ready_still_low", 64'(req_ready), 64'h0);
        wait_valid();
        check("stall_high", 64'(stat_stall), 64'h1);
        tick();
        check("stall_held", 64'(stat_stall), 64'h1);
        wait_idle();

        // Load coinciding with the final wait cycle; later loads leave the held response alone.
        do_load(3, 64'h1111_1111_2222_2222);
        word_b = 64'hAAAA_5555_CAFE_F00D;
        word_c = 64'h0BAD_0BAD_0BAD_0BAD;
        resp_accept = 1'b0;
        model_mem[3] = word_b;
        issue(64'd24, 16'h0505);
        repeat (LAT) tick();
        raw_load(3, word_b);
        check("wf_valid", 64'(resp_valid), 64'h1);
        check("wf_payload", resp_payload, word_b);
        do_load(3, word_c);
        tick();
        check("held_payload", resp_payload, word_b);
        wait_idle();
        issue(64'd24, 16'h0506);
        wait_idle();

        // Reset while responding with two requests queued.
        resp_accept = 1'b0;
        issue(64'd8, 16'h0601);
        issue(64'd16, 16'h0602);
        issue(64'd32, 16'h0603);
        wait_valid();
        tick();
        reset = 1'b1;
        #1;
        exp_q.delete();
        check("mid_rst_valid", 64'(resp_valid), 64'h0);
        check("mid_rst_ready", 64'(req_ready), 64'h1);
        check("mid_rst_stall", 64'(stat_stall), 64'h0);
        tick();
        reset       = 1'b0;
        resp_accept = 1'b1;
        repeat (20) tick();
        check("no_stale_resp", 64'(resp_valid), 64'h0);
        issue(64'd16, 16'h0604);
        wait_idle();

        // Randomized traffic under random backpressure.
        rnd_mode = 1'b1;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0:       a = 64'(MEM_WORDS) * 64'd8 + 64'($urandom_range(0, 1000));
                1:       a = {$urandom, $urandom} | (64'd1 << 40);
                default: a = 64'($urandom_range(0, MEM_WORDS * 8 - 1));
            endcase
            issue(a, 16'($urandom_range(0, 65535)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) tick();
            if ((n % 50) == 49) begin
                wait_idle();
                do_load($urandom_range(0, MEM_WORDS - 1), {$urandom, $urandom});
                rnd_mode = 1'b1;
            end
        end
        wait_idle();
        check("queue_drained", 64'(exp_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
